// File: rtl/stage_memory.sv
// Vector memory-access stage: one element transaction per lane over req/ack,
// assembling loads, writing stores, and presenting a registered writeback bundle.
module stage_memory #(
    parameter int registerSize = 8,
    parameter int vectorSize   = 4,
    parameter int addrWidth    = 16,
    parameter int regAddrSize  = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     in_valid,
    input  logic                                     memRead,
    input  logic                                     memWrite,
    input  logic                                     regWrEn,
    input  logic [regAddrSize-1:0]                   regDest,
    input  logic [addrWidth-1:0]                     addr_base,
    input  logic [vectorSize-1:0][registerSize-1:0]  vect_in,
    output logic                                     stall,
    output logic                                     mem_req,
    output logic                                     mem_we,
    output logic [addrWidth-1:0]                     mem_addr,
    output logic [registerSize-1:0]                  mem_wdata,
    input  logic [registerSize-1:0]                  mem_rdata,
    input  logic                                     mem_ack,
    output logic                                     out_valid,
    output logic                                     regWrEn_out,
    output logic [regAddrSize-1:0]                   regDest_out,
    output logic [vectorSize-1:0][registerSize-1:0]  vect_wb
);

    localparam int IW = $clog2(vectorSize);
    localparam logic [IW-1:0] LAST = IW'(vectorSize - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t state, state_n;

    logic [IW-1:0]                           idx;
    logic [addrWidth-1:0]                    base;
    logic [vectorSize-1:0][registerSize-1:0] data;
    logic [vectorSize-1:0][registerSize-1:0] buffer;
    logic [vectorSize-1:0][registerSize-1:0] ld_vec;
    logic                                    op_we;
    logic                                    wr_en;
    logic [regAddrSize-1:0]                  dest;

    logic mem_op;
    logic start;
    logic in_acc;
    logic last;
    logic done;

    assign mem_op = memRead | memWrite;
    assign in_acc = (state == ACCESS);
    assign start  = (state == IDLE) & in_valid & mem_op;
    assign last   = (idx == LAST);
    assign done   = in_acc & mem_ack & last;

    // Gated by reset so the stall and request drop the moment reset asserts
    assign stall     = reset & (start | (in_acc & ~(mem_ack & last)));
    assign mem_req   = reset & in_acc;
    assign mem_we    = op_we;
    assign mem_addr  = base + addrWidth'(idx);
    assign mem_wdata = data[idx];

    always_comb begin
        ld_vec      = buffer;
        ld_vec[idx] = mem_rdata;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (start) state_n = ACCESS;
            ACCESS: if (done)  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            base        <= '0;
            data        <= '0;
            buffer      <= '0;
            op_we       <= 1'b0;
            wr_en       <= 1'b0;
            dest        <= '0;
            out_valid   <= 1'b0;
            regWrEn_out <= 1'b0;
            regDest_out <= '0;
            vect_wb     <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    out_valid   <= 1'b0;
                    regWrEn_out <= 1'b0;
                    if (in_valid && !mem_op) begin
                        out_valid   <= 1'b1;
                        vect_wb     <= vect_in;
                        regWrEn_out <= regWrEn;
                        regDest_out <= regDest;
                    end
                    if (start) begin
                        idx   <= '0;
                        base  <= addr_base;
                        data  <= vect_in;
                        op_we <= memWrite;
                        wr_en <= regWrEn;
                        dest  <= regDest;
                    end
                end
                ACCESS: begin
                    out_valid   <= 1'b0;
                    regWrEn_out <= 1'b0;
                    if (mem_ack) begin
                        if (!op_we) buffer <= ld_vec;
                        if (!last) idx <= idx + IW'(1);
                    end
                    if (done) begin
                        out_valid   <= 1'b1;
                        regDest_out <= dest;
                        vect_wb     <= op_we ? data : ld_vec;
                        regWrEn_out <= op_we ? 1'b0 : wr_en;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory: pass-through, loads, stores with waits,
// address wrap, back-to-back ops and mid-access reset.
module tb_stage_memory;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             memRead;
    logic             memWrite;
    logic             regWrEn;
    logic [3:0]       regDest;
    logic [15:0]      addr_base;
    logic [3:0][7:0]  vect_in;
    logic             stall;
    logic             mem_req;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [7:0]       mem_wdata;
    logic [7:0]       mem_rdata;
    logic             mem_ack;
    logic             out_valid;
    logic             regWrEn_out;
    logic [3:0]       regDest_out;
    logic [3:0][7:0]  vect_wb;

    int checks;
    int failures;

    stage_memory #(
        .registerSize(8),
        .vectorSize  (4),
        .addrWidth   (16),
        .regAddrSize (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .regWrEn    (regWrEn),
        .regDest    (regDest),
        .addr_base  (addr_base),
        .vect_in    (vect_in),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .out_valid  (out_valid),
        .regWrEn_out(regWrEn_out),
        .regDest_out(regDest_out),
        .vect_wb    (vect_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        in_valid  = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        regWrEn   = 1'b0;
        regDest   = 4'd0;
        addr_base = 16'h0;
        vect_in   = 32'h0;
    endtask

    logic [7:0]  rd_a [4];
    logic [15:0] wrap_a [4];
    logic [7:0]  st_b [4];

    initial begin
        checks    = 0;
        failures  = 0;
        rd_a      = '{8'h11, 8'h22, 8'h33, 8'h44};
        wrap_a    = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        st_b      = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 8'h0;
        idle_in();

        // reset state
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wren", 32'(regWrEn_out), 32'd0);
        chk("rst_dest", 32'(regDest_out), 32'd0);
        chk("rst_vect", 32'(vect_wb), 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        reset = 1'b1;
        step();

        // pass-through
        in_valid = 1'b1;
        regWrEn  = 1'b1;
        regDest  = 4'd5;
        vect_in  = 32'hAABBCCDD;
        #1 chk("pt_stall", 32'(stall), 32'd0);
        step();
        idle_in();
        chk("pt_valid", 32'(out_valid), 32'd1);
        chk("pt_wren", 32'(regWrEn_out), 32'd1);
        chk("pt_dest", 32'(regDest_out), 32'd5);
        chk("pt_vect", 32'(vect_wb), 32'hAABBCCDD);
        step();
        chk("pt_drop_valid", 32'(out_valid), 32'd0);
        chk("pt_drop_wren", 32'(regWrEn_out), 32'd0);
        chk("pt_hold_vect", 32'(vect_wb), 32'hAABBCCDD);
        chk("pt_hold_dest", 32'(regDest_out), 32'd5);

        // stray ack in IDLE is ignored
        mem_ack = 1'b1;
        #1 chk("idle_ack_req", 32'(mem_req), 32'd0);
        step();
        mem_ack = 1'b0;
        chk("idle_ack_valid", 32'(out_valid), 32'd0);

        // zero-wait load
        in_valid  = 1'b1;
        memRead   = 1'b1;
        regWrEn   = 1'b1;
        regDest   = 4'd3;
        addr_base = 16'h0100;
        #1 chk("ld_start_stall", 32'(stall), 32'd1);
        chk("ld_start_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            idle_in();
            mem_ack   = 1'b1;
            mem_rdata = rd_a[i];
            #1;
            chk("ld_req", 32'(mem_req), 32'd1);
            chk("ld_we", 32'(mem_we), 32'd0);
            chk("ld_addr", 32'(mem_addr), 32'h0100 + 32'(i));
            chk("ld_stall", 32'(stall), (i == 3) ? 32'd0 : 32'd1);
            chk("ld_busy_valid", 32'(out_valid), 32'd0);
        end
        step();
        mem_ack = 1'b0;
        chk("ld_valid", 32'(out_valid), 32'd1);
        chk("ld_vect", 32'(vect_wb), 32'h44332211);
        chk("ld_wren", 32'(regWrEn_out), 32'd1);
        chk("ld_dest", 32'(regDest_out), 32'd3);
        #1 chk("ld_done_req", 32'(mem_req), 32'd0);

        // store with two wait cycles per lane
        step();
        in_valid  = 1'b1;
        memWrite  = 1'b1;
        regWrEn   = 1'b1;
        regDest   = 4'd7;
        addr_base = 16'h0200;
        vect_in   = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            for (int w = 0; w < 3; w++) begin
                step();
                idle_in();
                mem_ack = (w == 2);
                #1;
                chk("st_req", 32'(mem_req), 32'd1);
                chk("st_we", 32'(mem_we), 32'd1);
                chk("st_addr", 32'(mem_addr), 32'h0200 + 32'(i));
                chk("st_wdata", 32'(mem_wdata), 32'(st_b[i]));
                chk("st_stall", 32'(stall),
                    (i == 3 && w == 2) ? 32'd0 : 32'd1);
                chk("st_busy_valid", 32'(out_valid), 32'd0);
            end
        end
        step();
        mem_ack = 1'b0;
        chk("st_valid_13cyc", 32'(out_valid), 32'd1);
        chk("st_wren", 32'(regWrEn_out), 32'd0);
        chk("st_dest", 32'(regDest_out), 32'd7);
        chk("st_vect", 32'(vect_wb), 32'hDEADBEEF);

        // address wrap on load
        step();
        in_valid  = 1'b1;
        memRead   = 1'b1;
        addr_base = 16'hFFFE;
        for (int i = 0; i < 4; i++) begin
            step();
            idle_in();
            mem_ack   = 1'b1;
            mem_rdata = 8'hA0 + 8'(i);
            #1 chk("wrap_addr", 32'(mem_addr), 32'(wrap_a[i]));
        end
        step();
        mem_ack = 1'b0;
        chk("wrap_vect", 32'(vect_wb), 32'hA3A2A1A0);

        // back-to-back load then store presented during stall
        step();
        in_valid  = 1'b1;
        memRead   = 1'b1;
        addr_base = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            step();
            in_valid  = 1'b1;
            memRead   = 1'b0;
            memWrite  = 1'b1;
            addr_base = 16'h0400;
            vect_in   = 32'h0C0B0A09;
            mem_ack   = 1'b1;
            mem_rdata = 8'h05 + 8'(i);
            #1;
            chk("b2b_ld_we", 32'(mem_we), 32'd0);
            chk("b2b_ld_addr", 32'(mem_addr), 32'h0300 + 32'(i));
        end
        step();
        mem_ack = 1'b0;
        chk("b2b_ld_valid", 32'(out_valid), 32'd1);
        chk("b2b_ld_vect", 32'(vect_wb), 32'h08070605);
        #1 chk("b2b_st_start_stall", 32'(stall), 32'd1);
        chk("b2b_gap_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            idle_in();
            mem_ack = 1'b1;
            #1;
            chk("b2b_st_req", 32'(mem_req), 32'd1);
            chk("b2b_st_we", 32'(mem_we), 32'd1);
            chk("b2b_st_addr", 32'(mem_addr), 32'h0400 + 32'(i));
            chk("b2b_st_wdata", 32'(mem_wdata), 32'h09 + 32'(i));
        end
        step();
        mem_ack = 1'b0;
        chk("b2b_st_valid", 32'(out_valid), 32'd1);
        chk("b2b_st_wren", 32'(regWrEn_out), 32'd0);
        chk("b2b_st_vect", 32'(vect_wb), 32'h0C0B0A09);
        #1 chk("b2b_after_req", 32'(mem_req), 32'd0);

        // reset during lane 2 of a load
        step();
        in_valid  = 1'b1;
        memRead   = 1'b1;
        regWrEn   = 1'b1;
        regDest   = 4'd9;
        addr_base = 16'h0500;
        for (int i = 0; i < 2; i++) begin
            step();
            idle_in();
            mem_ack   = 1'b1;
            mem_rdata = 8'h77;
        end
        step();
        mem_ack = 1'b0;
        #1 chk("mr_lane2_addr", 32'(mem_addr), 32'h0502);
        reset = 1'b0;
        #1;
        chk("mr_req", 32'(mem_req), 32'd0);
        chk("mr_stall", 32'(stall), 32'd0);
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_wren", 32'(regWrEn_out), 32'd0);
        chk("mr_dest", 32'(regDest_out), 32'd0);
        chk("mr_vect", 32'(vect_wb), 32'h0);
        step();
        reset    = 1'b1;
        in_valid = 1'b1;
        vect_in  = 32'h01020304;
        #1 chk("mr_fresh_stall", 32'(stall), 32'd0);
        step();
        idle_in();
        chk("mr_fresh_valid", 32'(out_valid), 32'd1);
        chk("mr_fresh_vect", 32'(vect_wb), 32'h01020304);
        #1 chk("mr_no_resume", 32'(mem_req), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
# stage_memory

Vector memory-access stage placed directly downstream of the execute stage. It takes the per-lane execute result plus memory/writeback control and issues one element-wide transaction per lane to an external data memory over a req/ack handshake. Loads are assembled into a vector; stores are written lane by lane. While a vector access is in progress the stage stalls upstream, and it presents a registered writeback bundle to the writeback stage.

## Interface
- registerSize, 8, bits per vector element
- vectorSize, 4, lanes per vector (≥2)
- addrWidth, 16, data-memory address width
- regAddrSize, 4, destination register index width

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an instruction this cycle
- memRead  in  1  instruction is a vector load
- memWrite  in  1  instruction is a vector store
- regWrEn  in  1  instruction writes a vector register
- regDest  in  regAddrSize  destination register index
- addr_base  in  addrWidth  address of lane 0
- vect_in  in  vectorSize×registerSize  execute result (packed [vectorSize-1:0][registerSize-1:0]); store data or writeback data
- stall  out  1  hold upstream pipeline registers
- mem_req  out  1  memory transaction request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  addrWidth  transaction address
- mem_wdata  out  registerSize  store data
- mem_rdata  in  registerSize  load data, valid with mem_ack
- mem_ack  in  1  transaction completes this cycle
- out_valid  out  1  writeback bundle valid
- regWrEn_out  out  1  registered write enable (0 when out_valid=0)
- regDest_out  out  regAddrSize  registered destination
- vect_wb  out  vectorSize×registerSize  registered writeback vector

## Operation
- FSM with two states: IDLE and ACCESS.
- "start" = IDLE & in_valid & (memRead | memWrite). memRead and memWrite both high: treat as store.
- IDLE, in_valid, no mem op: on the next edge, out_valid=1, vect_wb=vect_in, regWrEn_out/regDest_out captured.
- IDLE & start: capture addr_base, vect_in, op, regWrEn, and regDest. Set lane index idx=0 and go to ACCESS. out_valid=0 on the next edge.
- IDLE, in_valid=0: out_valid=0 and regWrEn_out=0 on the next edge. vect_wb and regDest_out hold.
- ACCESS: mem_req=1, mem_we=op, mem_addr=base+idx (modulo 2^addrWidth, wraps), mem_wdata=data[idx]. All are driven combinationally from registers.
- ACCESS & mem_ack:
  - Load: buffer[idx] ← mem_rdata.
  - idx < vectorSize-1: idx++.
  - idx = vectorSize-1: go to IDLE and load the output registers.
    - Load: vect_wb = assembled buffer including this cycle's mem_rdata. regWrEn_out = captured regWrEn.
    - Store: vect_wb = captured store vector. regWrEn_out = 0.
    - Both: out_valid=1.
- ACCESS without mem_ack: all request outputs are held stable, and idx does not change.
- mem_ack while not in ACCESS: ignored.
- stall = start | (ACCESS & ~(mem_ack & idx==vectorSize-1)). It is combinational, and the mem_ack→stall path is permitted.
- Inputs are ignored while in ACCESS.
- Reset (async, any time, including mid-ACCESS): state=IDLE, idx=0, buffer=0, out_valid=0, regWrEn_out=0, regDest_out=0, vect_wb=0. mem_req=0 and stall=0 immediately; the aborted access is not completed.

## Timing
- Non-memory instruction: 1-cycle latency, stall never asserted.
- Memory instruction with zero-wait memory (mem_ack same cycle as mem_req): 1 start cycle + vectorSize ACCESS cycles. out_valid is asserted in the cycle after the last ack.
- Each ack-wait cycle adds 1 cycle.
- stall drops in the cycle of the final ack. The upstream stage advances on that edge, so the next instruction is seen in IDLE during the first out_valid cycle. Back-to-back memory ops therefore have no bubble beyond the start cycle.
- mem_addr, mem_we, and mem_wdata are stable for the entire time mem_req=1 for a given lane.

## Test plan
- Reset mid-ACCESS:
  - Stimulus: reset low for 1 cycle during lane 2.
  - Required response:
    - mem_req=0 and all outputs are 0 asynchronously.
    - After release, a fresh non-mem op with vect_in=0x01020304 gives out_valid=1 and vect_wb=0x01020304 one cycle later.
- Pass-through:
  - Stimulus: in_valid=1, no mem op, regWrEn=1, regDest=5, vect_in=0xAABBCCDD.
  - Required response: next cycle out_valid=1, regWrEn_out=1, regDest_out=5, vect_wb=0xAABBCCDD; stall stays 0.
- Load, zero-wait:
  - Stimulus: addr_base=0x0100, memory holds 0x11,0x22,0x33,0x44 at 0x0100–0x0103.
  - Required response:
    - mem_addr sequence 0x0100..0x0103 with mem_we=0.
    - stall=1 for 4 cycles (start plus 3 non-final lanes).
    - out_valid in cycle 6 with vect_wb=0x44332211 (lane 0 = LSB).
- Store with wait states:
  - Stimulus: vect_in=0xDEADBEEF, ack delayed 2 cycles per lane.
  - Required response:
    - Writes 0xEF,0xBE,0xAD,0xDE to base..base+3 with outputs held during waits.
    - regWrEn_out=0 on completion.
    - 13 cycles from start to out_valid.
- Address wrap:
  - Stimulus: addr_base=0xFFFE, load.
  - Required response: mem_addr = 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Back-to-back:
  - Stimulus: a load immediately followed by a store while stall is high.
  - Required response: the store is held until the load's final ack; the store's first mem_req occurs 2 cycles after that ack; no transaction is lost or duplicated.
